pipelined_adder_tree_acc: RTL and testbench
===========================================

Name: pipelined_adder_tree_acc

Overview:
- Parametrised successor of the single-stage adder tree: the full log2 reduction of NUM_INPUTS signed operands in one block.
- Pipeline registers are placed every PIPE_EVERY adder levels; a valid bit travels with the data.
- A tagged accumulator sums consecutive reduced vectors, for example the partial dot products of a convolution kernel spread over several beats.
- Sits between the PE multiplier array and the output quantiser of the DVE datapath.

Parameters:
- NUM_INPUTS, 36, number of operands per beat, ≥1.
- INPUT_WIDTH, 32, signed operand width.
- PIPE_EVERY, 1, adder levels between pipeline registers, ≥1.
- ACC_WIDTH, 48, signed accumulator/output width; must be ≥ INPUT_WIDTH+S (elaboration error otherwise).
- Derived S = $clog2(NUM_INPUTS), number of adder levels (0 when NUM_INPUTS=1).
- Derived L_TREE = 1 + ceil(S/PIPE_EVERY).
- Derived LATENCY = L_TREE + 1.

Ports:
- clk  in  1  clock.
- rst_in  in  1  synchronous reset, active-high.
- in_valid  in  1  beat qualifier.
- in_first  in  1  beat starts a new accumulation; sampled only when in_valid=1.
- in_last  in  1  beat ends the accumulation; sampled only when in_valid=1.
- in  in  NUM_INPUTS x INPUT_WIDTH  signed operands, index 0..NUM_INPUTS-1.
- out_valid  out  1  out holds a completed accumulation.
- out  out  ACC_WIDTH  signed accumulated sum.
- overflow_out  out  1  signed wrap occurred in the accumulator during this accumulation; qualified by out_valid.

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst_in, sampled at the rising edge of clk.
- Reset clears every valid/first/last pipeline bit, the accumulator, the sticky overflow flag, out (0), out_valid (0) and overflow_out (0). Data registers other than acc/out need no reset.
- No backpressure: one beat can be accepted every cycle; the result is produced LATENCY cycles after the beat that carries in_last.
- Stage 0 register: captures in, in_valid, in_first and in_last every cycle, always enabled.
- Level l (1..S): pairs operands 2i and 2i+1 into a sum one bit wider than level l-1.
  - An odd orphan operand is sign-extended by 1 bit and placed last.
  - No truncation; the tree sum width is INPUT_WIDTH+S, exact.
- A register bank (data plus valid/first/last) follows level l when l mod PIPE_EVERY == 0 or l == S.
- Tree sum emerges, registered, L_TREE cycles after input.
- Accumulator stage, active when the tree-output valid is 1:
  - first=1: acc <= sext(tree_sum), ovf <= 0.
  - first=0: acc <= acc + sext(tree_sum), wrapping modulo 2^ACC_WIDTH. ovf <= ovf OR signed-overflow (operands share a sign and the result sign differs).
  - last=1: next cycle out <= updated acc, overflow_out <= updated ovf, out_valid <= 1.
  - If first and last are both set, out is the single-beat sum and overflow_out is 0.
- out_valid is a one-cycle pulse. out holds its value until the next completed accumulation.
- in_first without a preceding in_last: the previous partial accumulation is discarded silently.
- in_last without a preceding in_first (or directly after reset): the beat adds onto the current acc (0 after reset).
- Bubbles (in_valid=0) leave acc untouched. Sidebands on bubbles are ignored, and bubbles may sit between the first and last beat.
- Reset mid-operation: in-flight beats are dropped. out_valid stays 0 until a full first..last sequence is accepted after reset deassertion.
- NUM_INPUTS=1: S=0, L_TREE=1, and the tree is a plain register.

Test Plan:
- Defaults (36, 32, PIPE_EVERY=1), LATENCY=8: all in=1 with first=last=1 at cycle 0 → out_valid pulse at cycle 8, out=36, overflow_out=0.
- PIPE_EVERY=2 (LATENCY=5): three beats, first on beat0 and last on beat2, in[i]=i, i, -1 → out = 630+630-36 = 1224 at 5 cycles after beat2. Repeat with two bubbles inserted between beats → same value, out_valid only once.
- Extreme operands: all in=-2^31 for one beat → out = -36·2^31 exactly. All in=2^31-1 → 36·(2^31-1), no overflow.
- ACC_WIDTH=38, NUM_INPUTS=36 (S=6): accumulate two beats of all 2^31-1 → out wraps negative, overflow_out=1. A following single beat with first=last=1 of zeros → out=0, overflow_out=0.
- Back-to-back results: first=last=1 on 10 consecutive beats with in[0]=k, others 0 (k=0..9) → out_valid high for 10 consecutive cycles, out=0..9 in order.
- Assert rst_in for 1 cycle while 4 beats are in flight → out_valid stays 0, acc=0; a subsequent last-only beat of all 1 → out=36.

Source files
------------

// File: rtl/pipelined_adder_tree_acc.sv
// Pipelined signed adder tree reducing NUM_INPUTS operands per beat, followed by
// a first/last tagged accumulator with sticky signed-overflow reporting.
module pipelined_adder_tree_acc #(
  parameter int NUM_INPUTS  = 36,
  parameter int INPUT_WIDTH = 32,
  parameter int PIPE_EVERY  = 1,
  parameter int ACC_WIDTH   = 48
) (
  input  logic                                    clk,
  input  logic                                    rst_in,
  input  logic                                    in_valid,
  input  logic                                    in_first,
  input  logic                                    in_last,
  input  logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0]  in,
  output logic                                    out_valid,
  output logic signed [ACC_WIDTH-1:0]             out,
  output logic                                    overflow_out
);

  localparam int S  = $clog2(NUM_INPUTS);
  localparam int TW = INPUT_WIDTH + S;

  function automatic int lvl_cnt(input int l);
    int n;
    n = NUM_INPUTS;
    for (int k = 0; k < l; k++) n = (n + 1) / 2;
    return n;
  endfunction

  if (ACC_WIDTH < TW) begin : g_bad_width
    $error("ACC_WIDTH must be at least INPUT_WIDTH + clog2(NUM_INPUTS)");
  end

  // Every level carries the full tree width; operands are sign-extended once at
  // entry, which gives the same exact sums as growing one bit per level.
  for (genvar l = 0; l <= S; l++) begin : g_lvl
    localparam int NL = lvl_cnt(l);
    logic signed [TW-1:0] w_q [NL];
    logic                 w_v;
    logic                 w_f;
    logic                 w_l;

    if (l == 0) begin : g_in
      logic signed [TW-1:0] r_d [NL];
      logic                 r_v;
      logic                 r_f;
      logic                 r_l;

      always_ff @(posedge clk) begin
        for (int i = 0; i < NL; i++) r_d[i] <= TW'($signed(in[i]));
        if (rst_in) begin
          r_v <= 1'b0;
          r_f <= 1'b0;
          r_l <= 1'b0;
        end else begin
          r_v <= in_valid;
          r_f <= in_first;
          r_l <= in_last;
        end
      end

      assign w_q = r_d;
      assign w_v = r_v;
      assign w_f = r_f;
      assign w_l = r_l;
    end else begin : g_add
      localparam int NP      = lvl_cnt(l - 1);
      localparam bit DO_REG  = ((l % PIPE_EVERY) == 0) || (l == S);
      logic signed [TW-1:0] w_s [NL];

      for (genvar i = 0; i < NL; i++) begin : g_pair
        if (2 * i + 1 < NP) begin : g_sum
          assign w_s[i] = g_lvl[l-1].w_q[2*i] + g_lvl[l-1].w_q[2*i+1];
        end else begin : g_orphan
          assign w_s[i] = g_lvl[l-1].w_q[2*i];
        end
      end

      if (DO_REG) begin : g_reg
        logic signed [TW-1:0] r_d [NL];
        logic                 r_v;
        logic                 r_f;
        logic                 r_l;

        always_ff @(posedge clk) begin
          r_d <= w_s;
          if (rst_in) begin
            r_v <= 1'b0;
            r_f <= 1'b0;
            r_l <= 1'b0;
          end else begin
            r_v <= g_lvl[l-1].w_v;
            r_f <= g_lvl[l-1].w_f;
            r_l <= g_lvl[l-1].w_l;
          end
        end

        assign w_q = r_d;
        assign w_v = r_v;
        assign w_f = r_f;
        assign w_l = r_l;
      end else begin : g_comb
        assign w_q = w_s;
        assign w_v = g_lvl[l-1].w_v;
        assign w_f = g_lvl[l-1].w_f;
        assign w_l = g_lvl[l-1].w_l;
      end
    end
  end

  logic signed [TW-1:0]        w_tree;
  logic                        w_tv;
  logic                        w_tf;
  logic                        w_tl;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                        r_ovf;
  logic signed [ACC_WIDTH-1:0] w_ext;
  logic signed [ACC_WIDTH-1:0] w_base;
  logic signed [ACC_WIDTH-1:0] w_next;
  logic                        w_ovf_prev;
  logic                        w_ovf_next;

  assign w_tree = g_lvl[S].w_q[0];
  assign w_tv   = g_lvl[S].w_v;
  assign w_tf   = g_lvl[S].w_f;
  assign w_tl   = g_lvl[S].w_l;

  // A first beat restarts from zero, so it can never raise the overflow flag.
  always_comb begin
    w_ext = ACC_WIDTH'(w_tree);
    if (w_tf) begin
      w_base     = '0;
      w_ovf_prev = 1'b0;
    end else begin
      w_base     = r_acc;
      w_ovf_prev = r_ovf;
    end
    w_next     = w_base + w_ext;
    w_ovf_next = w_ovf_prev |
                 ((w_base[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1]) &&
                  (w_next[ACC_WIDTH-1] != w_base[ACC_WIDTH-1]));
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_acc        <= '0;
      r_ovf        <= 1'b0;
      out          <= '0;
      out_valid    <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      out_valid <= w_tv & w_tl;
      if (w_tv) begin
        r_acc <= w_next;
        r_ovf <= w_ovf_next;
        if (w_tl) begin
          out          <= w_next;
          overflow_out <= w_ovf_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_tree_acc.sv
// Drives three configurations (default, PIPE_EVERY=2, ACC_WIDTH=38) with one
// stimulus stream; a reference accumulator per instance feeds a timed scoreboard.
module tb_pipelined_adder_tree_acc;

  localparam int N  = 36;
  localparam int IW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_in;
  logic                   vld;
  logic                   fst;
  logic                   lst;
  logic [N-1:0][IW-1:0]   din;
  logic [N-1:0][IW-1:0]   stage;

  logic                   ovv   [3];
  logic                   ovf_o [3];
  longint                 od    [3];
  logic signed [47:0]     out0;
  logic signed [47:0]     out1;
  logic signed [37:0]     out2;

  pipelined_adder_tree_acc #(.NUM_INPUTS(N), .INPUT_WIDTH(IW), .PIPE_EVERY(1), .ACC_WIDTH(48)) u_def (
    .clk(clk), .rst_in(rst_in), .in_valid(vld), .in_first(fst), .in_last(lst), .in(din),
    .out_valid(ovv[0]), .out(out0), .overflow_out(ovf_o[0]));

  pipelined_adder_tree_acc #(.NUM_INPUTS(N), .INPUT_WIDTH(IW), .PIPE_EVERY(2), .ACC_WIDTH(48)) u_p2 (
    .clk(clk), .rst_in(rst_in), .in_valid(vld), .in_first(fst), .in_last(lst), .in(din),
    .out_valid(ovv[1]), .out(out1), .overflow_out(ovf_o[1]));

  pipelined_adder_tree_acc #(.NUM_INPUTS(N), .INPUT_WIDTH(IW), .PIPE_EVERY(1), .ACC_WIDTH(38)) u_w38 (
    .clk(clk), .rst_in(rst_in), .in_valid(vld), .in_first(fst), .in_last(lst), .in(din),
    .out_valid(ovv[2]), .out(out2), .overflow_out(ovf_o[2]));

  assign od[0] = longint'(out0);
  assign od[1] = longint'(out1);
  assign od[2] = longint'(out2);

  typedef struct {
    int     k;
    longint val;
    bit     ovf;
    longint due;
  } exp_t;

  exp_t   q[$];
  int     lat_of [3] = '{8, 5, 8};
  int     w_of   [3] = '{48, 48, 38};
  longint macc     [3];
  bit     movf     [3];
  longint last_exp [3];
  longint cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint wrapw(input longint x, input int w);
    longint t;
    t = x << (64 - w);
    return t >>> (64 - w);
  endfunction

  task automatic set_all(input longint v);
    for (int i = 0; i < N; i++) stage[i] = IW'(v);
  endtask

  task automatic set_idx();
    for (int i = 0; i < N; i++) stage[i] = IW'(i);
  endtask

  task automatic beat(input bit f, input bit l);
    longint ts;
    longint base;
    longint nxt;
    bit     step;
    exp_t   e;
    @(posedge clk);
    #1;
    vld = 1'b1;
    fst = f;
    lst = l;
    din = stage;
    ts  = 0;
    for (int i = 0; i < N; i++) ts += longint'($signed(stage[i]));
    for (int k = 0; k < 3; k++) begin
      base = f ? 64'sd0 : macc[k];
      nxt  = wrapw(base + ts, w_of[k]);
      step = !f && ((base < 0) == (ts < 0)) && ((nxt < 0) != (base < 0));
      movf[k] = (f ? 1'b0 : movf[k]) | step;
      macc[k] = nxt;
      if (l) begin
        e.k   = k;
        e.val = nxt;
        e.ovf = movf[k];
        e.due = cyc + lat_of[k];
        q.push_back(e);
      end
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    vld = 1'b0;
    fst = 1'($urandom);
    lst = 1'($urandom);
    for (int i = 0; i < N; i++) din[i] = IW'($urandom);
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk);
    #1;
    rst_in = 1'b1;
    vld    = 1'b0;
    fst    = 1'b0;
    lst    = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1;
    rst_in = 1'b0;
    q.delete();
    for (int k = 0; k < 3; k++) begin
      macc[k] = 0;
      movf[k] = 1'b0;
      last_exp[k] = 0;
    end
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      assert (od[k] === 64'sd0) else begin
        n_bad++; $error("FAIL rst_out inst%0d: got %0d, want 0", k, od[k]);
      end
      n_cmp++;
      assert (ovv[k] === 1'b0) else begin
        n_bad++; $error("FAIL rst_valid inst%0d: got %b, want 0", k, ovv[k]);
      end
      n_cmp++;
      assert (ovf_o[k] === 1'b0) else begin
        n_bad++; $error("FAIL rst_ovf inst%0d: got %b, want 0", k, ovf_o[k]);
      end
    end
  endtask

  // Scoreboard: match each pulse to the oldest pending result of that instance.
  always @(negedge clk) begin
    int idx;
    for (int k = 0; k < 3; k++) begin
      if (ovv[k] === 1'b1) begin
        idx = -1;
        for (int j = 0; j < q.size(); j++) if (idx < 0 && q[j].k == k) idx = j;
        n_cmp++;
        assert (idx >= 0) else begin
          n_bad++; $error("FAIL unexpected_out inst%0d: out_valid=1 out=%0d, want no result", k, od[k]);
        end
        if (idx >= 0) begin
          n_cmp++;
          assert (od[k] === q[idx].val) else begin
            n_bad++; $error("FAIL out inst%0d: got %0d, want %0d", k, od[k], q[idx].val);
          end
          n_cmp++;
          assert (ovf_o[k] === q[idx].ovf) else begin
            n_bad++; $error("FAIL overflow inst%0d: got %b, want %b", k, ovf_o[k], q[idx].ovf);
          end
          n_cmp++;
          assert (cyc === q[idx].due) else begin
            n_bad++; $error("FAIL latency inst%0d: got cycle %0d, want %0d", k, cyc, q[idx].due);
          end
          last_exp[k] = q[idx].val;
          q.delete(idx);
        end
      end
    end
    for (int j = q.size() - 1; j >= 0; j--) begin
      if (q[j].due < cyc) begin
        n_cmp++;
        assert (q[j].due >= cyc) else begin
          n_bad++; $error("FAIL missing_out inst%0d: no pulse by cycle %0d, want %0d at %0d",
                          q[j].k, cyc, q[j].val, q[j].due);
        end
        q.delete(j);
      end
    end
  end

  initial begin
    rst_in = 1'b1;
    vld    = 1'b0;
    fst    = 1'b0;
    lst    = 1'b0;
    din    = '0;
    stage  = '0;
    do_reset(2);
    check_reset_state();

    set_all(1);                 beat(1'b1, 1'b1);
    repeat (10) idle();

    set_idx();                  beat(1'b1, 1'b0);
    set_idx();                  beat(1'b0, 1'b0);
    set_all(-1);                beat(1'b0, 1'b1);
    repeat (10) idle();

    set_idx();                  beat(1'b1, 1'b0);
    idle(); idle();
    set_idx();                  beat(1'b0, 1'b0);
    idle(); idle();
    set_all(-1);                beat(1'b0, 1'b1);
    repeat (10) idle();

    set_all(-64'sd2147483648);  beat(1'b1, 1'b1);
    set_all(64'sd2147483647);   beat(1'b1, 1'b1);
    repeat (10) idle();

    set_all(64'sd2147483647);   beat(1'b1, 1'b0);
    set_all(64'sd2147483647);   beat(1'b0, 1'b1);
    set_all(0);                 beat(1'b1, 1'b1);
    repeat (10) idle();

    for (int kk = 0; kk < 10; kk++) begin
      set_all(0);
      stage[0] = IW'(kk);
      beat(1'b1, 1'b1);
    end
    repeat (10) idle();

    set_all(5);                 beat(1'b1, 1'b0);
    set_all(2);                 beat(1'b1, 1'b1);
    repeat (10) idle();

    set_all(3);                 beat(1'b1, 1'b0);
    set_all(4);                 beat(1'b0, 1'b0);
    set_all(6);                 beat(1'b0, 1'b0);
    set_all(7);                 beat(1'b0, 1'b1);
    do_reset(1);
    check_reset_state();
    repeat (10) idle();
    set_all(1);                 beat(1'b0, 1'b1);
    repeat (12) idle();

    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      assert (od[k] === last_exp[k]) else begin
        n_bad++; $error("FAIL hold inst%0d: got %0d, want %0d", k, od[k], last_exp[k]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
